// File: rtl/sopc_irq_ctrl_pkg.sv
// Shared types, register offsets, reset values and bus helpers for the min-SOPC interrupt aggregator.
package sopc_irq_ctrl_pkg;

    localparam int unsigned BUS_W         = 32;
    localparam int unsigned OFF_W         = 4;
    localparam int unsigned MAX_LINE_REGS = 6;

    localparam logic [OFF_W-1:0] OFF_PEND    = 4'd0;
    localparam logic [OFF_W-1:0] OFF_MASK    = 4'd1;
    localparam logic [OFF_W-1:0] OFF_MODE    = 4'd2;
    localparam logic [OFF_W-1:0] OFF_POL     = 4'd3;
    localparam logic [OFF_W-1:0] OFF_RAW     = 4'd4;
    localparam logic [OFF_W-1:0] OFF_ACTIVE  = 4'd5;
    localparam logic [OFF_W-1:0] OFF_LINE_EN = 4'd8;

    // Only the timer (src0) is unmasked and routed to line 0 out of reset.
    localparam logic [BUS_W-1:0] RST_MASK     = 32'h0000_0001;
    localparam logic [BUS_W-1:0] RST_MODE     = 32'h0000_0000;
    localparam logic [BUS_W-1:0] RST_POL      = 32'h0000_0000;
    localparam logic [BUS_W-1:0] RST_LINE_EN0 = 32'h0000_0001;
    localparam logic [BUS_W-1:0] RST_LINE_EN  = 32'h0000_0000;

    typedef struct packed {
        logic             rd;
        logic             wr;
        logic [OFF_W-1:0] off;
        logic [BUS_W-1:0] bmask;
        logic [BUS_W-1:0] wdata;
    } bus_req_t;

    function automatic logic [BUS_W-1:0] byte_mask(input logic [3:0] sel);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old_v,
                                                     input logic [BUS_W-1:0] wdata,
                                                     input logic [BUS_W-1:0] bmask);
        return (old_v & ~bmask) | (wdata & bmask);
    endfunction

endpackage

// File: rtl/sopc_irq_ctrl_if.sv
// Data-bus slave port of the interrupt controller (same signalling as data_ram).
interface sopc_irq_ctrl_if;

    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output ce, output we, output addr, output sel, output data_in, input data_out);
    modport slave  (input ce, input we, input addr, input sel, input data_in, output data_out);

endinterface

// File: rtl/sopc_irq_ctrl_sync_edge.sv
// Per-source front end: synchroniser chain, polarity adjust and rising-edge detect on the adjusted level.
module sopc_irq_ctrl_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic pol_i,
    output logic adj_c,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(irq_i);
        adj_c  = sync_q[SYNC_STAGES-1] ^ pol_i;
        edge_c = adj_c & ~prev_q;
        prev_d = adj_c;
    end

    // prev resets low so a source held active through reset still yields one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/sopc_irq_ctrl.sv
// Interrupt aggregator: per-source mask/mode/polarity, W1C pending, per-line routing onto the CPU int_i vector.
module sopc_irq_ctrl
    import sopc_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned NUM_LINES   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq_i,
    sopc_irq_ctrl_if.slave       bus,
    output logic [NUM_LINES-1:0] int_o
);

    typedef logic [NUM_SRC-1:0] src_vec_t;

    bus_req_t             req_c;
    src_vec_t             wmask_c, wdata_c, w1c_c;
    src_vec_t             adj_c, edge_c;
    src_vec_t             pend_q, pend_d;
    src_vec_t             mask_q, mask_d;
    src_vec_t             mode_q, mode_d;
    src_vec_t             pol_q, pol_d;
    src_vec_t             line_en_q [NUM_LINES];
    src_vec_t             line_en_d [NUM_LINES];
    logic [NUM_LINES-1:0] int_q, int_d;
    logic [BUS_W-1:0]     rdata_c;
    logic                 unused_addr_c;

    always_comb begin : decode
        req_c.wr    = bus.ce & bus.we;
        req_c.rd    = bus.ce & ~bus.we;
        req_c.off   = bus.addr[5:2];
        req_c.bmask = byte_mask(bus.sel);
        req_c.wdata = bus.data_in;
    end

    assign wmask_c       = NUM_SRC'(req_c.bmask);
    assign wdata_c       = NUM_SRC'(req_c.wdata);
    assign unused_addr_c = ^{bus.addr[31:6], bus.addr[1:0]};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        sopc_irq_ctrl_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_i[i]),
            .pol_i  (pol_q[i]),
            .adj_c  (adj_c[i]),
            .edge_c (edge_c[i])
        );
    end

    // Byte-masked register writes; bits at or above NUM_SRC are dropped by the truncating casts.
    always_comb begin : reg_write
        mask_d    = mask_q;
        mode_d    = mode_q;
        pol_d     = pol_q;
        line_en_d = line_en_q;
        w1c_c     = '0;
        if (req_c.wr) begin
            case (req_c.off)
                OFF_PEND: w1c_c  = wdata_c & wmask_c;
                OFF_MASK: mask_d = NUM_SRC'(merge_bytes(32'(mask_q), req_c.wdata, req_c.bmask));
                OFF_MODE: mode_d = NUM_SRC'(merge_bytes(32'(mode_q), req_c.wdata, req_c.bmask));
                OFF_POL:  pol_d  = NUM_SRC'(merge_bytes(32'(pol_q), req_c.wdata, req_c.bmask));
                default: ;
            endcase
            for (int unsigned j = 0; j < NUM_LINES; j++) begin
                if (j < MAX_LINE_REGS && req_c.off == OFF_LINE_EN + 4'(j)) begin
                    line_en_d[j] = NUM_SRC'(merge_bytes(32'(line_en_q[j]), req_c.wdata, req_c.bmask));
                end
            end
        end
    end

    // Mode change wins, then level tracks adj, else edge set beats a same-cycle W1C.
    always_comb begin : pend_next
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i] != mode_d[i]) begin
                pend_d[i] = 1'b0;
            end else if (!mode_q[i]) begin
                pend_d[i] = adj_c[i];
            end else begin
                pend_d[i] = (pend_q[i] & ~w1c_c[i]) | edge_c[i];
            end
        end
    end

    always_comb begin : route
        int_d = '0;
        for (int unsigned j = 0; j < NUM_LINES; j++) begin
            int_d[j] = |(pend_q & mask_q & line_en_q[j]);
        end
    end

    always_comb begin : read_mux
        rdata_c = '0;
        if (req_c.rd) begin
            case (req_c.off)
                OFF_PEND:   rdata_c = 32'(pend_q);
                OFF_MASK:   rdata_c = 32'(mask_q);
                OFF_MODE:   rdata_c = 32'(mode_q);
                OFF_POL:    rdata_c = 32'(pol_q);
                OFF_RAW:    rdata_c = 32'(adj_c);
                OFF_ACTIVE: rdata_c = 32'(pend_q & mask_q);
                default: ;
            endcase
            for (int unsigned j = 0; j < NUM_LINES; j++) begin
                if (j < MAX_LINE_REGS && req_c.off == OFF_LINE_EN + 4'(j)) begin
                    rdata_c = 32'(line_en_q[j]);
                end
            end
        end
    end

    assign bus.data_out = rdata_c;
    assign int_o        = int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= NUM_SRC'(RST_MASK);
            mode_q <= NUM_SRC'(RST_MODE);
            pol_q  <= NUM_SRC'(RST_POL);
            int_q  <= '0;
            for (int unsigned j = 0; j < NUM_LINES; j++) begin
                line_en_q[j] <= (j == 0) ? NUM_SRC'(RST_LINE_EN0) : NUM_SRC'(RST_LINE_EN);
            end
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            int_q     <= int_d;
            line_en_q <= line_en_d;
        end
    end

endmodule
